// File: rtl/axis_pkt_arb_mux_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_arb_mux_if
// Bundle of N parallel AXI4-Stream channels, flattened so channel n occupies
// slice n of every vector. The arbiter uses one instance with N=S_COUNT for
// its inputs and one with N=1 for its output.
//   master : drives tdata/tkeep/tvalid/tlast/tuser, receives tready
//   slave  : receives tdata/tkeep/tvalid/tlast/tuser, drives tready
// -----------------------------------------------------------------------------
interface axis_pkt_arb_mux_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N*USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pkt_arb_mux.sv
// -----------------------------------------------------------------------------
// axis_pkt_arb_mux
// Packet-level round-robin arbiter in front of a shared AXI4-Stream FIFO.
// One input is granted per packet and keeps the grant until its tlast beat
// transfers; beats pass through a two-entry skid stage and are tagged with
// the source index.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   s_axis       : S_COUNT input streams (slave side of the bundle)
//   m_axis       : single output stream (master side of the bundle)
//   m_axis_tid   : source index travelling with each output beat
// -----------------------------------------------------------------------------
module axis_pkt_arb_mux #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int CL_S_COUNT  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_pkt_arb_mux_if.slave     s_axis,
    axis_pkt_arb_mux_if.master    m_axis,
    output logic [CL_S_COUNT-1:0] m_axis_tid
);
    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH + CL_S_COUNT;

    typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [CL_S_COUNT-1:0]  grant_idx_q, grant_idx_d;
    logic [CL_S_COUNT-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CL_S_COUNT-1:0]  arb_idx;
    logic [CL_S_COUNT:0]    arb_cand;
    logic                   arb_found;

    logic                   out_ready_int_q, out_ready_int_early;
    logic                   m_valid_q, m_valid_d;
    logic                   temp_valid_q, temp_valid_d;
    logic [BEAT_W-1:0]      m_beat_q, m_beat_d;
    logic [BEAT_W-1:0]      temp_beat_q, temp_beat_d;

    logic                   in_xfer;
    logic                   in_last;
    logic [KEEP_WIDTH-1:0]  in_keep;
    logic [BEAT_W-1:0]      in_beat;

    // Round-robin pick: walk offsets from far to near so the nearest
    // requester at or after the pointer is the one left standing.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            arb_cand = {1'b0, rr_ptr_q} + (CL_S_COUNT+1)'(i);
            if (arb_cand >= (CL_S_COUNT+1)'(S_COUNT)) begin
                arb_cand = arb_cand - (CL_S_COUNT+1)'(S_COUNT);
            end
            if (s_axis.tvalid[arb_cand[CL_S_COUNT-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand[CL_S_COUNT-1:0];
            end
        end
    end

    // Only the granted port sees ready, and only while a packet is open.
    genvar gi;
    generate
        for (gi = 0; gi < S_COUNT; gi++) begin : g_ready
            assign s_axis.tready[gi] = (state_q == ACTIVE) &&
                                       (grant_idx_q == CL_S_COUNT'(gi)) &&
                                       out_ready_int_q;
        end

        if (LAST_ENABLE != 0) begin : g_last
            assign in_last = s_axis.tlast[grant_idx_q];
        end else begin : g_no_last
            assign in_last = 1'b1;
        end

        if (KEEP_ENABLE != 0) begin : g_keep
            assign in_keep = s_axis.tkeep[grant_idx_q*KEEP_WIDTH +: KEEP_WIDTH];
        end else begin : g_no_keep
            assign in_keep = '1;
        end
    endgenerate

    assign in_xfer = (state_q == ACTIVE) && s_axis.tvalid[grant_idx_q] && out_ready_int_q;
    assign in_beat = {grant_idx_q,
                      s_axis.tuser[grant_idx_q*USER_WIDTH +: USER_WIDTH],
                      in_last,
                      in_keep,
                      s_axis.tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH]};

    // Ready for next cycle: the temp slot is empty and will not be filled
    // by this cycle's beat (output drains, or the output register is free).
    assign out_ready_int_early = m_axis.tready[0] ||
                                 (!temp_valid_q && (!m_valid_q || !in_xfer));

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        rr_ptr_d     = rr_ptr_q;
        m_valid_d    = m_valid_q;
        temp_valid_d = temp_valid_q;
        m_beat_d     = m_beat_q;
        temp_beat_d  = temp_beat_q;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d     = ACTIVE;
                    grant_idx_d = arb_idx;
                end
            end
            ACTIVE: begin
                if (in_xfer && in_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_idx_q == CL_S_COUNT'(S_COUNT - 1)) ? '0
                                                                        : grant_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Skid stage: while accepting, the beat goes straight to the output
        // register if that is free or draining, otherwise parks in temp.
        // While not accepting, temp refills the output as it drains.
        if (out_ready_int_q) begin
            if (m_axis.tready[0] || !m_valid_q) begin
                m_valid_d = in_xfer;
                m_beat_d  = in_beat;
            end else begin
                temp_valid_d = in_xfer;
                temp_beat_d  = in_beat;
            end
        end else if (m_axis.tready[0]) begin
            m_valid_d    = temp_valid_q;
            m_beat_d     = temp_beat_q;
            temp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_idx_q     <= '0;
            rr_ptr_q        <= '0;
            m_valid_q       <= 1'b0;
            temp_valid_q    <= 1'b0;
            out_ready_int_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_idx_q     <= grant_idx_d;
            rr_ptr_q        <= rr_ptr_d;
            m_valid_q       <= m_valid_d;
            temp_valid_q    <= temp_valid_d;
            out_ready_int_q <= out_ready_int_early;
        end
    end

    // Beat payload needs no reset; its valid flags qualify it.
    always_ff @(posedge clk) begin
        m_beat_q    <= m_beat_d;
        temp_beat_q <= temp_beat_d;
    end

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_beat_q[DATA_WIDTH-1:0];
    assign m_axis.tkeep  = m_beat_q[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis.tlast  = m_beat_q[DATA_WIDTH + KEEP_WIDTH];
    assign m_axis.tuser  = m_beat_q[DATA_WIDTH + KEEP_WIDTH + 1 +: USER_WIDTH];
    assign m_axis_tid    = m_beat_q[BEAT_W-1 -: CL_S_COUNT];
endmodule
